cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sin/cos CORDIC engine between N requesters.
- Accepts angle requests over a valid/ready handshake and drives the engine's level-sensitive start / ready handshake.
- Captures sin/cos and returns them to the granted requester over a valid/ready response channel.
- Watchdog aborts a hung engine transaction with an error response.

Parameters:
- N, 4, number of requesters (2..8)
- W, 12, angle/result width, fixpoint(2:10), matches engine
- TIMEOUT, 1023, max cycles from issue to engine ready before abort
- CW, 10, watchdog counter width; must hold TIMEOUT

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  N  request pending, per requester
- req_angle  in  N*W  angles, requester k at bits [k*W +: W]
- req_ready  out  N  one-cycle accept pulse, one-hot
- rsp_valid  out  N  result available, one-hot
- rsp_sin  out  W  result sine (shared bus)
- rsp_cos  out  W  result cosine (shared bus)
- rsp_err  out  1  result invalid due to watchdog abort
- rsp_ready  in  N  requester consumes result
- eng_start  out  1  engine start level
- eng_angle  out  W  engine angle_in
- eng_ready  in  1  engine ready_out
- eng_sin  in  W  engine sin_out
- eng_cos  in  W  engine cos_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high, clock "clock"):
  - All outputs go to 0; state goes to IDLE.
  - Round-robin pointer last goes to N-1, so requester 0 has first priority.
  - Watchdog count goes to 0.
  - Reset mid-transaction discards the transaction with no response. Forcing eng_start low returns the engine to idle.
- All outputs are registered.
- States: IDLE, WAIT_LO, WAIT_HI, CAPTURE, RESP.
- IDLE:
  - If any req_valid is set, g is the first set index searching last+1, last+2, ... modulo N.
  - Next cycle: req_ready[g]=1 for exactly one cycle, eng_angle<=req_angle[g], eng_start<=1, last<=g, count<=0, go to WAIT_LO.
  - Requesters hold req_valid and angle until req_ready. The angle is latched, so it may change after accept.
- WAIT_LO: eng_ready may still be high from the previous job. Wait for eng_ready==0, then go to WAIT_HI.
- WAIT_HI: wait for eng_ready==1, then go to CAPTURE.
- CAPTURE (one cycle):
  - rsp_sin<=eng_sin, rsp_cos<=eng_cos, rsp_err<=0, eng_start<=0.
  - rsp_valid[g]<=1, go to RESP.
- Watchdog:
  - count increments each cycle in WAIT_LO and WAIT_HI.
  - When count==TIMEOUT: eng_start<=0, rsp_sin=rsp_cos=0, rsp_err=1, rsp_valid[g]<=1, go to RESP.
- RESP:
  - Hold rsp_valid[g] and the data until rsp_ready[g]==1.
  - On that cycle rsp_valid clears next cycle and state goes to IDLE.
  - rsp_ready on non-granted lines is ignored.
- eng_start is low for at least 2 cycles (RESP, IDLE) between jobs, which guarantees the engine re-enters its idle state.
- New requests arriving during a transaction are not accepted. They wait; there is no queueing.
- Simultaneous requests are granted in round-robin order; no requester waits more than N-1 grants.
- A requester dropping req_valid before req_ready is legal; it is not granted.
- Latency, req_valid to rsp_valid with engine latency E cycles (start seen to ready high): E + 4 cycles.
- Width rule: results pass through unmodified, W bits, no rescaling.

Test Plan:
- Single request, req 0, angle 12'h324 (pi/4 in 2:10) with engine model -> req_ready[0] pulses once; rsp_valid[0] with sin = cos = 12'h2D4 ±2 LSB, rsp_err=0.
- All 4 requesters valid at once, rsp_ready tied high -> grant order 0,1,2,3; next round again 0,1,2,3; each response on the matching rsp_valid bit only.
- Stale ready: engine model holds eng_ready=1 until 2 cycles after start -> controller does not capture before eng_ready has dropped and risen; results correspond to the new angle.
- Engine stuck, eng_ready never rises -> after TIMEOUT+1 cycles, rsp_err=1, rsp_sin=rsp_cos=0, eng_start=0; the next request completes normally.
- Backpressure: rsp_ready[1] held low 20 cycles while req 2 is valid -> rsp data stable, busy=1, req_ready[2] only after the RESP handshake.
- Reset asserted in WAIT_HI -> next cycle all outputs 0, eng_start=0; after release, req 0 is granted first.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one sin/cos CORDIC engine between N requesters.
// A watchdog turns a hung engine job into an error response.
module cordic_arbiter #(
   parameter int N       = 4,
   parameter int W       = 12,
   parameter int TIMEOUT = 1023,
   parameter int CW      = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N-1:0]        req_valid,
   input  logic [N*W-1:0]      req_angle,
   output logic [N-1:0]        req_ready,
   output logic [N-1:0]        rsp_valid,
   output logic signed [W-1:0] rsp_sin,
   output logic signed [W-1:0] rsp_cos,
   output logic                rsp_err,
   input  logic [N-1:0]        rsp_ready,
   output logic                eng_start,
   output logic [W-1:0]        eng_angle,
   input  logic                eng_ready,
   input  logic signed [W-1:0] eng_sin,
   input  logic signed [W-1:0] eng_cos,
   output logic                busy
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, WAIT_LO, WAIT_HI, CAPTURE, RESP} state_t;

   state_t state, next_state;
   // last doubles as the index of the granted requester for the whole job
   logic [IW-1:0] last, next_last;
   logic [CW-1:0] count, next_count;

   logic [N-1:0]        next_req_ready, next_rsp_valid;
   logic signed [W-1:0] next_sin, next_cos;
   logic                next_err, next_start, next_busy;
   logic [W-1:0]        next_angle;

   logic          found, timed_out;
   logic [IW-1:0] pick, cand;
   logic [W-1:0]  pick_angle;

   always_comb begin
      found = 1'b0;
      pick  = last;
      cand  = last;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last) + i) % N);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      pick_angle = '0;
      for (int k = 0; k < N; k++)
         if (pick == IW'(k)) pick_angle = req_angle[k*W +: W];
   end

   always_comb begin
      next_state     = state;
      next_last      = last;
      next_count     = count;
      next_req_ready = '0;
      next_rsp_valid = rsp_valid;
      next_sin       = rsp_sin;
      next_cos       = rsp_cos;
      next_err       = rsp_err;
      next_start     = eng_start;
      next_angle     = eng_angle;
      timed_out      = (count == CW'(TIMEOUT));

      case (state)
         IDLE: begin
            if (found) begin
               next_req_ready[pick] = 1'b1;
               next_angle           = pick_angle;
               next_start           = 1'b1;
               next_last            = pick;
               next_count           = '0;
               next_state           = WAIT_LO;
            end
         end
         WAIT_LO: begin
            // ready may still be asserted from the previous job; wait for it to fall
            if (!timed_out) begin
               next_count = count + 1'b1;
               if (!eng_ready) next_state = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (eng_ready)       next_state = CAPTURE;
            else if (!timed_out) next_count = count + 1'b1;
         end
         CAPTURE: begin
            next_sin             = eng_sin;
            next_cos             = eng_cos;
            next_err             = 1'b0;
            next_start           = 1'b0;
            next_rsp_valid       = '0;
            next_rsp_valid[last] = 1'b1;
            next_state           = RESP;
         end
         RESP: begin
            if (rsp_ready[last]) begin
               next_rsp_valid = '0;
               next_state     = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      // watchdog abort: answer the requester with an error and release the engine
      if (timed_out && (state == WAIT_LO || (state == WAIT_HI && !eng_ready))) begin
         next_start           = 1'b0;
         next_sin             = '0;
         next_cos             = '0;
         next_err             = 1'b1;
         next_rsp_valid       = '0;
         next_rsp_valid[last] = 1'b1;
         next_state           = RESP;
      end

      next_busy = (next_state != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         last      <= IW'(N - 1);
         count     <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_sin   <= '0;
         rsp_cos   <= '0;
         rsp_err   <= 1'b0;
         eng_start <= 1'b0;
         eng_angle <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= next_state;
         last      <= next_last;
         count     <= next_count;
         req_ready <= next_req_ready;
         rsp_valid <= next_rsp_valid;
         rsp_sin   <= next_sin;
         rsp_cos   <= next_cos;
         rsp_err   <= next_err;
         eng_start <= next_start;
         eng_angle <= next_angle;
         busy      <= next_busy;
      end
   end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: behavioural CORDIC engine stand-in plus a
// round-robin reference model, driven with randomized angles and request masks.
module tb_cordic_arbiter;
   localparam int N       = 4;
   localparam int W       = 12;
   localparam int TIMEOUT = 1023;
   localparam int CW      = 10;
   localparam int IW      = 2;
   localparam int E_LAT   = 5;

   logic           clock;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_angle;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_sin;
   logic [W-1:0]   rsp_cos;
   logic           rsp_err;
   logic [N-1:0]   rsp_ready;
   logic           eng_start;
   logic [W-1:0]   eng_angle;
   logic           eng_ready;
   logic [W-1:0]   eng_sin;
   logic [W-1:0]   eng_cos;
   logic           busy;

   logic [W-1:0] ang [N];
   bit           stale_mode;
   bit           stuck_mode;
   int           run_cnt;
   int           n_tests;
   int           n_fail;
   int           model_last;

   cordic_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_angle (req_angle),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_sin   (rsp_sin),
      .rsp_cos   (rsp_cos),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .eng_start (eng_start),
      .eng_angle (eng_angle),
      .eng_ready (eng_ready),
      .eng_sin   (eng_sin),
      .eng_cos   (eng_cos),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      req_angle = '0;
      for (int k = 0; k < N; k++) req_angle[k*W +: W] = ang[k];
   end

   function automatic logic [W-1:0] f_sin(input logic [W-1:0] a);
      real r;
      r = $itor($signed(a)) / 1024.0;
      return W'($rtoi($floor($sin(r) * 1024.0 + 0.5)));
   endfunction

   function automatic logic [W-1:0] f_cos(input logic [W-1:0] a);
      real r;
      r = $itor($signed(a)) / 1024.0;
      return W'($rtoi($floor($cos(r) * 1024.0 + 0.5)));
   endfunction

   // Engine stand-in: level start, ready E_LAT cycles after start is seen,
   // ready dropped when start falls (or, in stale mode, 2 cycles into the next job).
   always @(posedge clock) begin
      if (reset) begin
         eng_ready <= 1'b0;
         eng_sin   <= '0;
         eng_cos   <= '0;
         run_cnt   <= 0;
      end else if (!eng_start) begin
         run_cnt <= 0;
         if (!stale_mode) eng_ready <= 1'b0;
      end else begin
         run_cnt <= run_cnt + 1;
         if (run_cnt == 1) eng_ready <= 1'b0;
         if (run_cnt == E_LAT && !stuck_mode) begin
            eng_ready <= 1'b1;
            eng_sin   <= f_sin(eng_angle);
            eng_cos   <= f_cos(eng_angle);
         end
      end
   end

   function automatic logic [N-1:0] onehot(input int k);
      onehot = '0;
      if (k >= 0 && k < N) onehot[k[IW-1:0]] = 1'b1;
   endfunction

   function automatic int model_pick(input logic [N-1:0] m);
      int k;
      for (int i = 1; i <= N; i++) begin
         k = (model_last + i) % N;
         if (m[k[IW-1:0]]) return k;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] rand_angle();
      return W'($urandom_range(1600, 0));
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(output int g, output logic [N-1:0] seen);
      g = -1;
      seen = '0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (req_ready != '0) begin
            seen = req_ready;
            for (int k = 0; k < N; k++) if (req_ready[k[IW-1:0]]) g = k;
            req_valid[g[IW-1:0]] = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_rsp(input int maxc, output int cyc);
      cyc = -1;
      for (int c = 1; c <= maxc; c++) begin
         tick();
         if (rsp_valid != '0) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick(); tick();
      n_tests++;
      if ({req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, eng_start, eng_angle, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b sin=%h cos=%h err=%b st=%b ang=%h busy=%b, want all 0",
                  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, eng_start, eng_angle, busy);
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if ({req_ready, busy} !== '0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got rdy=%b busy=%b, want 0", req_ready, busy);
      end
      model_last = N - 1;
   endtask

   task automatic test_round_robin();
      int g, cyc;
      logic [N-1:0] seen;
      logic [W-1:0] a;
      rsp_ready = '1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N; k++) ang[k] = rand_angle();
         req_valid = '1;
         for (int j = 0; j < N; j++) begin
            wait_grant(g, seen);
            n_tests++;
            if (g !== j || seen !== onehot(j)) begin
               n_fail++;
               $display("FAIL rr_order: round %0d got grant %0d (req_ready=%b), want %0d", r, g, seen, j);
            end
            if (g < 0) return;
            a = ang[g[IW-1:0]];
            ang[g[IW-1:0]] = rand_angle();
            model_last = g;
            wait_rsp(40, cyc);
            n_tests++;
            if (rsp_valid !== onehot(g)) begin
               n_fail++;
               $display("FAIL rr_rsp_valid: got %b want %b", rsp_valid, onehot(g));
            end
            n_tests++;
            if (rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a) || rsp_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_data: got sin=%h cos=%h err=%b want sin=%h cos=%h err=0",
                        rsp_sin, rsp_cos, rsp_err, f_sin(a), f_cos(a));
            end
         end
      end
      tick();
      rsp_ready = '0;
   endtask

   task automatic test_single();
      int cyc, pulses, ds, dc;
      logic [N-1:0] other;
      ang[0] = 12'h324;
      rsp_ready = 4'b0001;
      req_valid = 4'b0001;
      cyc = 0; pulses = 0; other = '0;
      for (int c = 0; c < 40; c++) begin
         tick();
         cyc++;
         if (req_ready[0]) begin
            pulses++;
            req_valid[0] = 1'b0;
         end
         other |= req_ready & 4'b1110;
         if (rsp_valid != '0) break;
      end
      n_tests++;
      if (pulses != 1 || other !== '0) begin
         n_fail++;
         $display("FAIL single_accept: got %0d pulses on req_ready[0], other=%b, want 1 and 0000", pulses, other);
      end
      n_tests++;
      if (cyc != E_LAT + 4) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles want %0d", cyc, E_LAT + 4);
      end
      n_tests++;
      if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rsp: got vld=%b err=%b want 0001 err=0", rsp_valid, rsp_err);
      end
      ds = int'($signed(rsp_sin)) - 724;
      dc = int'($signed(rsp_cos)) - 724;
      n_tests++;
      if (ds > 2 || ds < -2 || dc > 2 || dc < -2) begin
         n_fail++;
         $display("FAIL single_pi4: got sin=%h cos=%h want 2d4 +-2", rsp_sin, rsp_cos);
      end
      tick();
      n_tests++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got vld=%b busy=%b want 0000 0", rsp_valid, busy);
      end
      rsp_ready = '0;
      model_last = 0;
   endtask

   task automatic test_random();
      int g, exp_g, cyc, hold, k0;
      logic [N-1:0] seen;
      logic [W-1:0] a;
      rsp_ready = '0;
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < N; k++)
            if (!req_valid[k[IW-1:0]] && $urandom_range(1, 0) == 1) begin
               ang[k] = rand_angle();
               req_valid[k[IW-1:0]] = 1'b1;
            end
         if (req_valid == '0) begin
            k0 = $urandom_range(N - 1, 0);
            ang[k0] = rand_angle();
            req_valid[k0[IW-1:0]] = 1'b1;
         end
         exp_g = model_pick(req_valid);
         wait_grant(g, seen);
         n_tests++;
         if (g !== exp_g || seen !== onehot(exp_g)) begin
            n_fail++;
            $display("FAIL rand_grant: iter %0d got %0d (req_ready=%b) want %0d", it, g, seen, exp_g);
         end
         if (g < 0) return;
         a = ang[g[IW-1:0]];
         ang[g[IW-1:0]] = rand_angle();
         model_last = g;
         if ($urandom_range(3, 0) == 0) begin
            k0 = $urandom_range(N - 1, 0);
            req_valid[k0[IW-1:0]] = 1'b0;
         end
         rsp_ready = N'($urandom_range(15, 0)) & ~onehot(g);
         wait_rsp(40, cyc);
         n_tests++;
         if (rsp_valid !== onehot(g) || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a) || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_rsp: got vld=%b sin=%h cos=%h err=%b want vld=%b sin=%h cos=%h err=0",
                     rsp_valid, rsp_sin, rsp_cos, rsp_err, onehot(g), f_sin(a), f_cos(a));
         end
         hold = $urandom_range(3, 0);
         repeat (hold) tick();
         n_tests++;
         if (rsp_valid !== onehot(g) || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a)) begin
            n_fail++;
            $display("FAIL rand_hold: got vld=%b sin=%h cos=%h after %0d cycles want vld=%b sin=%h cos=%h",
                     rsp_valid, rsp_sin, rsp_cos, hold, onehot(g), f_sin(a), f_cos(a));
         end
         rsp_ready = onehot(g) | N'($urandom_range(15, 0));
         tick();
         rsp_ready = '0;
         n_tests++;
         if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL rand_release: got vld=%b want 0000", rsp_valid);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int g, cyc, bad;
      logic [N-1:0] seen;
      logic [W-1:0] a, s0, c0;
      rsp_ready = '0;
      ang[1] = rand_angle();
      req_valid = 4'b0010;
      wait_grant(g, seen);
      n_tests++;
      if (g !== 1) begin
         n_fail++;
         $display("FAIL bp_grant1: got %0d want 1", g);
      end
      if (g < 0) return;
      model_last = 1;
      ang[2] = rand_angle();
      req_valid[2] = 1'b1;
      wait_rsp(40, cyc);
      s0 = rsp_sin;
      c0 = rsp_cos;
      rsp_ready = 4'b1101;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rsp_valid !== 4'b0010 || rsp_sin !== s0 || rsp_cos !== c0 || busy !== 1'b1 || req_ready !== '0)
            bad++;
      end
      n_tests++;
      if (bad != 0 || cyc < 0) begin
         n_fail++;
         $display("FAIL bp_hold: got %0d unstable cycles (rsp seen at %0d), want 0", bad, cyc);
      end
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      n_tests++;
      if (rsp_valid !== '0 || req_ready !== '0) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0000 0000", rsp_valid, req_ready);
      end
      tick();
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_grant2: got req_ready=%b want 0100", req_ready);
      end
      req_valid[2] = 1'b0;
      model_last = 2;
      a = ang[2];
      wait_rsp(40, cyc);
      n_tests++;
      if (rsp_valid !== 4'b0100 || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a)) begin
         n_fail++;
         $display("FAIL bp_rsp2: got vld=%b sin=%h cos=%h want 0100 %h %h", rsp_valid, rsp_sin, rsp_cos, f_sin(a), f_cos(a));
      end
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = '0;
   endtask

   task automatic test_stale_ready();
      int g, cyc;
      logic [N-1:0] seen;
      logic [W-1:0] a, b;
      stale_mode = 1'b1;
      rsp_ready = '1;
      a = W'($urandom_range(700, 0));
      b = a + 12'd600;
      ang[3] = a;
      req_valid = 4'b1000;
      wait_grant(g, seen);
      model_last = 3;
      wait_rsp(40, cyc);
      n_tests++;
      if (g !== 3 || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a)) begin
         n_fail++;
         $display("FAIL stale_first: got grant %0d sin=%h cos=%h want 3 %h %h", g, rsp_sin, rsp_cos, f_sin(a), f_cos(a));
      end
      tick();
      ang[0] = b;
      req_valid = 4'b0001;
      wait_grant(g, seen);
      model_last = 0;
      wait_rsp(40, cyc);
      n_tests++;
      if (g !== 0 || rsp_valid !== 4'b0001 || rsp_sin !== f_sin(b) || rsp_cos !== f_cos(b) || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_second: got grant %0d vld=%b sin=%h cos=%h err=%b want 0 0001 %h %h 0",
                  g, rsp_valid, rsp_sin, rsp_cos, rsp_err, f_sin(b), f_cos(b));
      end
      tick();
      rsp_ready = '0;
      stale_mode = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_watchdog();
      int g, cyc;
      logic [N-1:0] seen;
      logic [W-1:0] a;
      stuck_mode = 1'b1;
      rsp_ready = '0;
      ang[1] = rand_angle();
      req_valid = 4'b0010;
      wait_grant(g, seen);
      n_tests++;
      if (g !== 1) begin
         n_fail++;
         $display("FAIL wd_grant: got %0d want 1", g);
      end
      model_last = 1;
      wait_rsp(TIMEOUT + 20, cyc);
      n_tests++;
      if (cyc != TIMEOUT + 1) begin
         n_fail++;
         $display("FAIL wd_timing: got abort after %0d cycles want %0d", cyc, TIMEOUT + 1);
      end
      n_tests++;
      if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_sin !== '0 || rsp_cos !== '0 || eng_start !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_rsp: got vld=%b err=%b sin=%h cos=%h start=%b want 0010 1 000 000 0",
                  rsp_valid, rsp_err, rsp_sin, rsp_cos, eng_start);
      end
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      stuck_mode = 1'b0;
      a = rand_angle();
      ang[2] = a;
      req_valid = 4'b0100;
      wait_grant(g, seen);
      model_last = 2;
      wait_rsp(40, cyc);
      n_tests++;
      if (g !== 2 || rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a)) begin
         n_fail++;
         $display("FAIL wd_recover: got grant %0d vld=%b err=%b sin=%h cos=%h want 2 0100 0 %h %h",
                  g, rsp_valid, rsp_err, rsp_sin, rsp_cos, f_sin(a), f_cos(a));
      end
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = '0;
   endtask

   task automatic test_reset_mid();
      int g, exp_g, cyc;
      logic [N-1:0] seen;
      logic [W-1:0] a;
      rsp_ready = '0;
      ang[2] = rand_angle();
      req_valid = 4'b0100;
      wait_grant(g, seen);
      model_last = 2;
      tick();
      tick();
      n_tests++;
      if (g !== 2 || busy !== 1'b1 || eng_start !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_inflight: got grant %0d busy=%b start=%b want 2 1 1", g, busy, eng_start);
      end
      reset = 1'b1;
      tick();
      n_tests++;
      if ({req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, eng_start, eng_angle, busy} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got rdy=%b vld=%b sin=%h cos=%h err=%b st=%b ang=%h busy=%b want all 0",
                  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, eng_start, eng_angle, busy);
      end
      reset = 1'b0;
      model_last = N - 1;
      ang[0] = rand_angle();
      ang[3] = rand_angle();
      a = ang[0];
      req_valid = 4'b1001;
      exp_g = model_pick(req_valid);
      wait_grant(g, seen);
      n_tests++;
      if (g !== exp_g) begin
         n_fail++;
         $display("FAIL rst_priority: got grant %0d want %0d", g, exp_g);
      end
      model_last = g;
      wait_rsp(40, cyc);
      n_tests++;
      if (rsp_valid !== 4'b0001 || rsp_sin !== f_sin(a) || rsp_cos !== f_cos(a) || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after_rsp: got vld=%b sin=%h cos=%h err=%b want 0001 %h %h 0",
                  rsp_valid, rsp_sin, rsp_cos, rsp_err, f_sin(a), f_cos(a));
      end
      rsp_ready = '1;
      tick();
      rsp_ready = '0;
      req_valid = '0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "bench timeout");
   end

   initial begin
      n_tests = 0;
      n_fail = 0;
      model_last = N - 1;
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      stale_mode = 1'b0;
      stuck_mode = 1'b0;
      for (int k = 0; k < N; k++) ang[k] = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_random();
      test_backpressure();
      test_stale_ready();
      test_watchdog();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
